// File: rtl/alu_mul_sequencer.sv
// Shift-add 8x8 unsigned multiplier that drives an external combinational ALU,
// issuing one ADD or SHR per clock and assembling the 16-bit product {P_hi, Q}.
module alu_mul_sequencer #(
    parameter int         WIDTH  = 8,
    parameter logic [3:0] OP_ADD = 4'b0000,
    parameter logic [3:0] OP_SHR = 4'b0101
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A_in,
    input  logic [WIDTH-1:0]   B_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P,
    output logic               ovf,
    output logic               zero,
    output logic               alu_sel,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic [WIDTH-1:0]   alu_flg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SHR  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  m;
    logic [WIDTH-1:0]  p_hi;
    logic [WIDTH-1:0]  q;
    logic              c;
    logic [2:0]        cnt;

    // Only the carry flag matters; the remaining ALU flags are deliberately dropped.
    logic unused_flg;
    assign unused_flg = ^alu_flg[WIDTH-1:1];

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign alu_sel = busy;
    assign P       = {p_hi, q};
    assign ovf     = |p_hi;
    assign zero    = (P == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        alu_op     = OP_ADD;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = B_in[0] ? ADD : SHR;
                end
            end
            ADD: begin
                alu_a      = p_hi;
                alu_b      = m;
                state_next = SHR;
            end
            SHR: begin
                alu_op = OP_SHR;
                alu_a  = p_hi;
                // q[1] is the multiplier bit that becomes q[0] after this shift.
                if (cnt == 3'd7) begin
                    state_next = DONE;
                end else begin
                    state_next = q[1] ? ADD : SHR;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m    <= '0;
            p_hi <= '0;
            q    <= '0;
            c    <= 1'b0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m    <= A_in;
                        q    <= B_in;
                        p_hi <= '0;
                        c    <= 1'b0;
                        cnt  <= '0;
                    end
                end
                ADD: begin
                    p_hi <= alu_out;
                    c    <= alu_flg[0];
                end
                SHR: begin
                    // Carry from the preceding ADD re-enters as the new top bit.
                    p_hi <= {c, alu_out[WIDTH-2:0]};
                    q    <= {p_hi[0], q[WIDTH-1:1]};
                    c    <= 1'b0;
                    if (cnt != 3'd7) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer: product, latency and handshake checked
// every cycle against a transaction-level model, plus literal directed cases.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  A_in, B_in;
    logic        busy, done, ovf, zero, alu_sel;
    logic [15:0] P;
    logic [7:0]  alu_a, alu_b, alu_out, alu_flg;
    logic [3:0]  alu_op;

    int total = 0;
    int bad   = 0;

    alu_mul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A_in(A_in), .B_in(B_in),
        .busy(busy), .done(done), .P(P), .ovf(ovf), .zero(zero),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flg(alu_flg)
    );

    always #5 clk = ~clk;

    // Combinational ALU: ADD with carry in flg[0], SHR logical by one.
    always_comb begin
        alu_out = 8'h00;
        alu_flg = 8'h00;
        case (alu_op)
            4'b0000: {alu_flg[0], alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0101: alu_out = alu_a >> 1;
            default: begin
            end
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted start costs 9+popcount(B) busy cycles,
    // the last of which is the done cycle carrying A*B.
    int          m_left;
    int          m_pop;
    logic [15:0] m_P, m_pend;
    logic [7:0]  m_M;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_P    <= 16'h0;
            m_pend <= 16'h0;
            m_M    <= 8'h0;
            m_pop  <= 0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= 9 + $countones(B_in);
                m_pend <= 16'(A_in) * 16'(B_in);
                m_M    <= A_in;
                m_pop  <= $countones(B_in);
            end
        end else begin
            if (m_left == 1) m_P <= m_pend;
            m_left <= m_left - 1;
        end
    end

    int          adds = 0;
    logic        e_busy, e_done;
    logic [15:0] e_P;

    always @(negedge clk) begin
        e_busy = (m_left != 0);
        e_done = (m_left == 1);
        e_P    = e_done ? m_pend : m_P;
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("alu_sel", alu_sel, e_busy);
        if (!e_busy) adds = 0;
        if (!e_busy || e_done) begin
            check("P", P, e_P);
            check("ovf", ovf, e_P[15:8] != 8'h00);
            check("zero", zero, e_P == 16'h0);
            check("idle_alu", {alu_op, alu_a, alu_b}, 20'h0);
        end else if (alu_op == 4'b0000) begin
            adds++;
            check("add_b", alu_b, m_M);
        end else begin
            check("shr_op_b", {alu_op, alu_b}, {4'b0101, 8'h00});
        end
        if (e_done) check("add_count", adds, m_pop);
    end

    // Runs one operation from an idle cycle. Returns cyc = done cycle number
    // (0 if aborted by reset); ends one cycle after done, i.e. in IDLE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [31:0] poke, input bit poke_done, input int rst_at,
                          output int cyc, output logic [15:0] pd, output logic ov, output logic zr);
        A_in  = a;
        B_in  = b;
        start = 1'b1;
        pd = 16'h0; ov = 1'b0; zr = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done) begin
            if (cyc >= 40) begin
                total++;
                bad++;
                $display("FAIL done_timeout: got no done expected done by cycle 17");
                return;
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                check("midrst_busy", busy, 1'b0);
                check("midrst_done", done, 1'b0);
                check("midrst_P", P, 16'h0);
                check("midrst_zero", zero, 1'b1);
                check("midrst_alu", {alu_sel, alu_op, alu_a, alu_b}, 21'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                cyc = 0;
                return;
            end
            A_in  = 8'($urandom);
            B_in  = 8'($urandom);
            start = (cyc < 32) ? poke[cyc] : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        pd = P; ov = ovf; zr = zero;
        start = poke_done;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    int          cyc;
    logic [15:0] pd;
    logic        ov, zr;
    logic [7:0]  ra, rb;

    initial begin
        rst_n = 1'b0; start = 1'b0; A_in = 8'h0; B_in = 8'h0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_P", P, 16'h0);
        check("rst_zero", zero, 1'b1);
        check("rst_ovf", ovf, 1'b0);
        check("rst_alu", {alu_sel, alu_op, alu_a, alu_b}, 21'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'd13, 8'd11, 0, 0, -1, cyc, pd, ov, zr);
        check("d13x11_lat", cyc, 12);
        check("d13x11_P", pd, 16'd143);
        check("d13x11_flags", {ov, zr}, 2'b00);

        run_op(8'hFF, 8'hFF, 0, 0, -1, cyc, pd, ov, zr);
        check("dFFxFF_lat", cyc, 17);
        check("dFFxFF_P", pd, 16'hFE01);
        check("dFFxFF_ovf", ov, 1'b1);

        run_op(8'h5A, 8'h00, 0, 0, -1, cyc, pd, ov, zr);
        check("d5Ax00_lat", cyc, 9);
        check("d5Ax00_P", pd, 16'h0);
        check("d5Ax00_flags", {ov, zr}, 2'b01);

        run_op(8'h80, 8'h02, 32'h8, 1, -1, cyc, pd, ov, zr);
        check("d80x02_P", pd, 16'h0100);
        check("d80x02_ovf", ov, 1'b1);
        check("d80x02_ign_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("d80x02_hold_P", P, 16'h0100);

        run_op(8'd7, 8'd9, 0, 0, 5, cyc, pd, ov, zr);
        check("d7x9_aborted", cyc, 0);
        repeat (3) @(posedge clk);
        #1;
        run_op(8'd7, 8'd9, 0, 0, -1, cyc, pd, ov, zr);
        check("d7x9_P", pd, 16'd63);

        run_op(8'd3, 8'd4, 0, 0, -1, cyc, pd, ov, zr);
        check("b2b_first_P", pd, 16'd12);
        run_op(8'd2, 8'd2, 0, 0, -1, cyc, pd, ov, zr);
        check("b2b_second_P", pd, 16'd4);
        check("b2b_second_lat", cyc, 10);

        for (int n = 0; n < 80; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n % 10 == 0) rb = 8'hFF;
            if (n % 10 == 1) ra = 8'hFF;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(ra, rb, $urandom, 1'($urandom), ($urandom_range(0, 11) == 0) ? $urandom_range(1, 15) : -1,
                   cyc, pd, ov, zr);
            if (cyc != 0) begin
                check("rand_P", pd, 16'(ra) * 16'(rb));
                check("rand_lat", cyc, 9 + $countones(rb));
            end
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
